// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - upstream/downstream handshake bundle for alu_issue_stage
interface alu_issue_stage_if #(
  parameter int DW   = 32,
  parameter int TAGW = 5
);
  logic            In_Valid;
  logic            In_Ready;
  logic [5:0]      In_Opcode;
  logic [5:0]      In_Func;
  logic [DW-1:0]   In_Rs;
  logic [DW-1:0]   In_Rt;
  logic [15:0]     In_Imm;
  logic [TAGW-1:0] In_Rd;
  logic            Out_Valid;
  logic            Out_Ready;
  logic [DW-1:0]   Out_A;
  logic [DW-1:0]   Out_B;
  logic [3:0]      Out_Op;
  logic [TAGW-1:0] Out_Rd;

  // Environment side: offers instructions, consumes ALU entries.
  modport master (
    output In_Valid, In_Opcode, In_Func, In_Rs, In_Rt, In_Imm, In_Rd, Out_Ready,
    input  In_Ready, Out_Valid, Out_A, Out_B, Out_Op, Out_Rd
  );

  // Issue stage side.
  modport slave (
    input  In_Valid, In_Opcode, In_Func, In_Rs, In_Rt, In_Imm, In_Rd, Out_Ready,
    output In_Ready, Out_Valid, Out_A, Out_B, Out_Op, Out_Rd
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: decode, operand select, 2-entry skid buffer (option: ALU_ISSUE_STATS_EN)
module alu_issue_stage #(
  parameter int DW   = 32,
  parameter int TAGW = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Flush,
  alu_issue_stage_if.slave     bus,
  output logic                 Illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]          Issue_Cnt,
  output logic [15:0]          Illegal_Cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [3:0]      op;
    logic [TAGW-1:0] rd;
  } entry_t;

  entry_t dec_entry;
  logic   dec_legal;

  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  logic   illegal_q, illegal_d;
  logic   accept, push, take;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;
`endif

  // Decode the offered instruction into ALU operands, op code and legality.
  always_comb begin
    logic [DW-1:0] se;
    logic [DW-1:0] zf;
    se = {{(DW-16){bus.In_Imm[15]}}, bus.In_Imm};
    zf = {{(DW-16){1'b0}}, bus.In_Imm};
    dec_entry.a  = '0;
    dec_entry.b  = '0;
    dec_entry.op = 4'b0000;
    dec_entry.rd = bus.In_Rd;
    dec_legal    = 1'b0;
    case (bus.In_Opcode)
      6'b100000: begin
        dec_entry.a  = bus.In_Rs;
        dec_entry.b  = bus.In_Rt;
        dec_entry.op = bus.In_Func[3:0];
        case (bus.In_Func)
          6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
          6'b111000, 6'b111001, 6'b111010, 6'b111100, 6'b111101: dec_legal = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      6'b111000: begin
        dec_entry.b = se;
        dec_legal   = 1'b1;
      end
      6'b111001: begin
        dec_entry.b = {bus.In_Imm, {(DW-16){1'b0}}};
        dec_legal   = 1'b1;
      end
      6'b110000: begin
        dec_entry.a = bus.In_Rs;
        dec_entry.b = se;
        dec_legal   = 1'b1;
      end
      6'b110010: begin
        dec_entry.a  = bus.In_Rs;
        dec_entry.b  = zf;
        dec_entry.op = 4'b0010;
        dec_legal    = 1'b1;
      end
      6'b110011: begin
        dec_entry.a  = bus.In_Rs;
        dec_entry.b  = zf;
        dec_entry.op = 4'b0011;
        dec_legal    = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Skid-buffer next state: M feeds the ALU, S catches an accept while M stalls.
  always_comb begin
    m_valid_d = m_valid_q;
    m_d       = m_q;
    s_valid_d = s_valid_q;
    s_d       = s_q;
    illegal_d = 1'b0;
    accept    = bus.In_Valid & ~s_valid_q;
    push      = accept & dec_legal;
    take      = m_valid_q & bus.Out_Ready;
    if (Flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else begin
      illegal_d = accept & ~dec_legal;
      if (s_valid_q) begin
        // In_Ready is low here, so no accept can collide with the S->M move.
        if (take) begin
          m_d       = s_q;
          s_valid_d = 1'b0;
        end
      end else if (~m_valid_q | take) begin
        m_valid_d = push;
        if (push) m_d = dec_entry;
      end else if (push) begin
        s_valid_d = 1'b1;
        s_d       = dec_entry;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Free-running wrap-around statistics; Flush deliberately leaves them alone.
  always_comb begin
    issue_cnt_d   = issue_cnt_q + {15'd0, take};
    illegal_cnt_d = illegal_cnt_q + {15'd0, illegal_d};
  end

  // Statistics registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign Issue_Cnt   = issue_cnt_q;
  assign Illegal_Cnt = illegal_cnt_q;
`endif

  // Buffer and pulse registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_valid_q <= 1'b0;
      m_q       <= '0;
      s_valid_q <= 1'b0;
      s_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_q       <= m_d;
      s_valid_q <= s_valid_d;
      s_q       <= s_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.In_Ready  = ~s_valid_q;
  assign bus.Out_Valid = m_valid_q;
  assign bus.Out_A     = m_q.a;
  assign bus.Out_B     = m_q.b;
  assign bus.Out_Op    = m_q.op;
  assign bus.Out_Rd    = m_q.rd;
  assign Illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic clk;
  logic reset_n;
  logic flush;
  logic illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt;
  logic [15:0] illegal_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_stage_if #(.DW(32), .TAGW(5)) bus ();

  alu_issue_stage #(.DW(32), .TAGW(5)) dut (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .Flush       (flush),
    .bus         (bus),
    .Illegal     (illegal)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .Issue_Cnt   (issue_cnt),
    .Illegal_Cnt (illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] imm, input logic [4:0] rd);
    bus.In_Valid  = 1'b1;
    bus.In_Opcode = op;
    bus.In_Func   = fn;
    bus.In_Rs     = rs;
    bus.In_Rt     = rt;
    bus.In_Imm    = imm;
    bus.In_Rd     = rd;
  endtask

  task automatic chk_out(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] rd);
    n_tests++;
    if (bus.Out_Valid !== 1'b1 || bus.Out_A !== a || bus.Out_B !== b || bus.Out_Op !== op || bus.Out_Rd !== rd) begin
      n_fail++;
      $display("FAIL %s: got v=%b A=%h B=%h Op=%h Rd=%0d, expected v=1 A=%h B=%h Op=%h Rd=%0d",
               name, bus.Out_Valid, bus.Out_A, bus.Out_B, bus.Out_Op, bus.Out_Rd, a, b, op, rd);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    bus.In_Valid = 1'b0; bus.In_Opcode = '0; bus.In_Func = '0; bus.In_Rs = '0;
    bus.In_Rt = '0; bus.In_Imm = '0; bus.In_Rd = '0; bus.Out_Ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.Out_Valid, bus.Out_A, bus.Out_B, bus.Out_Op, bus.Out_Rd, illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b A=%h B=%h Op=%h Rd=%0d Ill=%b, expected all zero",
               bus.Out_Valid, bus.Out_A, bus.Out_B, bus.Out_Op, bus.Out_Rd, illegal);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.In_Ready !== 1'b1 || bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got In_Ready=%b Out_Valid=%b, expected 1 0", bus.In_Ready, bus.Out_Valid);
    end
  endtask

  task automatic test_illegal();
    bus.Out_Ready = 1'b1;
    set_instr(6'b000111, 6'b0, 32'h1, 32'h2, 16'h3, 5'd1);
    @(negedge clk);
    n_tests++;
    if (illegal !== 1'b1 || bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_opcode: got Illegal=%b Out_Valid=%b, expected 1 0", illegal, bus.Out_Valid);
    end
    set_instr(6'b100000, 6'b110101, 32'h1, 32'h2, 16'h3, 5'd2);
    @(negedge clk);
    n_tests++;
    if (illegal !== 1'b1 || bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_func: got Illegal=%b Out_Valid=%b, expected 1 0", illegal, bus.Out_Valid);
    end
    bus.In_Valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (illegal !== 1'b0 || bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse_end: got Illegal=%b Out_Valid=%b, expected 0 0", illegal, bus.Out_Valid);
    end
`ifdef ALU_ISSUE_STATS_EN
    n_tests++;
    if (illegal_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL illegal_cnt: got %0d, expected 2", illegal_cnt);
    end
`endif
  endtask

  task automatic test_rtype();
    bus.Out_Ready = 1'b1;
    set_instr(6'b100000, 6'b110001, 32'hAAAA_0000, 32'h0000_5555, 16'h0, 5'd7);
    @(negedge clk);
    chk_out("rtype_sub", 32'hAAAA_0000, 32'h0000_5555, 4'b0001, 5'd7);
    set_instr(6'b100000, 6'b111101, 32'h0000_00F0, 32'h0000_0004, 16'hFFFF, 5'd31);
    @(negedge clk);
    chk_out("rtype_func_3d", 32'h0000_00F0, 32'h0000_0004, 4'b1101, 5'd31);
    n_tests++;
    if (illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_no_illegal: got Illegal=%b, expected 0", illegal);
    end
    bus.In_Valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_drain: got Out_Valid=%b, expected 0", bus.Out_Valid);
    end
  endtask

  task automatic test_addi();
    bus.Out_Ready = 1'b1;
    set_instr(6'b110000, 6'b0, 32'h0000_0005, 32'h0, 16'hFFFF, 5'd3);
    @(negedge clk);
    chk_out("addi", 32'h0000_0005, 32'hFFFF_FFFF, 4'b0000, 5'd3);
    bus.In_Valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_drain: got Out_Valid=%b, expected 0", bus.Out_Valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.Out_Ready = 1'b1;
    set_instr(6'b111001, 6'b0, 32'hDEAD_BEEF, 32'h0, 16'h1234, 5'd1);
    @(negedge clk);
    chk_out("b2b_lui", 32'h0, 32'h1234_0000, 4'b0000, 5'd1);
    set_instr(6'b110011, 6'b0, 32'h1234_0000, 32'h0, 16'h5678, 5'd2);
    @(negedge clk);
    chk_out("b2b_ori", 32'h1234_0000, 32'h0000_5678, 4'b0011, 5'd2);
    bus.In_Valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got Out_Valid=%b, expected 0", bus.Out_Valid);
    end
  endtask

  task automatic test_backpressure();
    bus.Out_Ready = 1'b0;
    set_instr(6'b110000, 6'b0, 32'h0000_0001, 32'h0, 16'h0001, 5'd4);
    @(negedge clk);
    chk_out("bp_first", 32'h1, 32'h1, 4'b0000, 5'd4);
    set_instr(6'b110010, 6'b0, 32'hFFFF_FFFF, 32'h0, 16'h8000, 5'd5);
    @(negedge clk);
    n_tests++;
    if (bus.In_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_low: got In_Ready=%b, expected 0", bus.In_Ready);
    end
    set_instr(6'b111000, 6'b0, 32'h1111_1111, 32'h0, 16'h8000, 5'd6);
    @(negedge clk);
    chk_out("bp_stable", 32'h1, 32'h1, 4'b0000, 5'd4);
    n_tests++;
    if (bus.In_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_third_blocked: got In_Ready=%b, expected 0", bus.In_Ready);
    end
    bus.Out_Ready = 1'b1;
    @(negedge clk);
    chk_out("bp_second", 32'hFFFF_FFFF, 32'h0000_8000, 4'b0010, 5'd5);
    @(negedge clk);
    chk_out("bp_third", 32'h0, 32'hFFFF_8000, 4'b0000, 5'd6);
    bus.In_Valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: got Out_Valid=%b In_Ready=%b, expected 0 1", bus.Out_Valid, bus.In_Ready);
    end
`ifdef ALU_ISSUE_STATS_EN
    n_tests++;
    if (issue_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL issue_cnt: got %0d, expected 8", issue_cnt);
    end
`endif
  endtask

  task automatic test_flush();
    bus.Out_Ready = 1'b0;
    set_instr(6'b110000, 6'b0, 32'h10, 32'h0, 16'h1, 5'd8);
    @(negedge clk);
    set_instr(6'b110000, 6'b0, 32'h20, 32'h0, 16'h2, 5'd9);
    @(negedge clk);
    set_instr(6'b110000, 6'b0, 32'h30, 32'h0, 16'h3, 5'd10);
    flush = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: got Out_Valid=%b In_Ready=%b Illegal=%b, expected 0 1 0",
               bus.Out_Valid, bus.In_Ready, illegal);
    end
    flush = 1'b0;
    set_instr(6'b110000, 6'b0, 32'h40, 32'h0, 16'h4, 5'd11);
    @(negedge clk);
    chk_out("post_flush_load", 32'h40, 32'h4, 4'b0000, 5'd11);
    set_instr(6'b000001, 6'b0, 32'h0, 32'h0, 16'h0, 5'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.In_Valid = 1'b0;
    n_tests++;
    if (bus.Out_Valid !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_illegal: got Out_Valid=%b Illegal=%b, expected 0 0", bus.Out_Valid, illegal);
    end
    @(negedge clk);
    n_tests++;
    if (bus.Out_Valid !== 1'b0 || illegal !== 1'b0 || bus.In_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_settle: got Out_Valid=%b Illegal=%b In_Ready=%b, expected 0 0 1",
               bus.Out_Valid, illegal, bus.In_Ready);
    end
  endtask

  task automatic test_async_reset();
    bus.Out_Ready = 1'b0;
    set_instr(6'b110011, 6'b0, 32'hCAFE_0000, 32'h0, 16'hBEEF, 5'd12);
    @(negedge clk);
    set_instr(6'b110011, 6'b0, 32'h0F0F_0000, 32'h0, 16'h00FF, 5'd13);
    @(negedge clk);
    bus.In_Valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.Out_Valid, bus.Out_A, bus.Out_B, bus.Out_Op, bus.Out_Rd, illegal} !== '0 || bus.In_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b A=%h B=%h Op=%h Rd=%0d Ill=%b Rdy=%b, expected zeros and Rdy=1",
               bus.Out_Valid, bus.Out_A, bus.Out_B, bus.Out_Op, bus.Out_Rd, illegal, bus.In_Ready);
    end
`ifdef ALU_ISSUE_STATS_EN
    n_tests++;
    if (issue_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got issue=%0d illegal=%0d, expected 0 0", issue_cnt, illegal_cnt);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    bus.Out_Ready = 1'b1;
    set_instr(6'b110010, 6'b0, 32'h0000_00FF, 32'h0, 16'hF00F, 5'd14);
    @(negedge clk);
    chk_out("after_reset", 32'h0000_00FF, 32'h0000_F00F, 4'b0010, 5'd14);
    bus.In_Valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_rtype();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage directly upstream of the 32-bit ALU.
- Accepts decoded instruction fields plus register-file read data over a valid/ready handshake.
- Forms the ALU operands (register or extended immediate) and the 4-bit ALU op code, then presents registered A/B/Op plus a destination tag to the ALU/writeback side through a 2-entry skid buffer.
- Illegal encodings are flagged and dropped.

Parameters:
- DW, 32: operand/data width. Fixed at 32 for this ISA; other values unsupported.
- TAGW, 5: destination register tag width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous clear of all buffered entries.
- In_Valid  input  1  upstream offers an instruction.
- In_Ready  output  1  stage can accept this cycle.
- In_Opcode  input  6  instruction opcode.
- In_Func  input  6  R-type function field.
- In_Rs  input  DW  rs read data.
- In_Rt  input  DW  rt read data.
- In_Imm  input  16  immediate field.
- In_Rd  input  TAGW  destination tag; passed through unchanged.
- Out_Valid  output  1  entry presented to ALU.
- Out_Ready  input  1  consumer takes the entry.
- Out_A  output  DW  ALU operand A.
- Out_B  output  DW  ALU operand B.
- Out_Op  output  4  ALU op code.
- Out_Rd  output  TAGW  destination tag.
- Illegal  output  1  one-cycle pulse: an illegal instruction was dropped.

Behaviour:
- Reset (Reset_n=0, asynchronous): both buffer entries invalid; Out_Valid=0, Out_A=0, Out_B=0, Out_Op=0, Out_Rd=0, Illegal=0, In_Ready=1 after release.
- Decode (combinational on inputs). SE = sign-extend(In_Imm); ZF = {16'h0, In_Imm}.
  - 100000 (R-type): A=In_Rs, B=In_Rt, Op=In_Func[3:0]. Legal only for In_Func in {110000, 110001, 110010, 110011, 110100, 111000, 111001, 111010, 111100, 111101}.
  - 111000 li: A=0, B=SE, Op=0000.
  - 111001 lui: A=0, B={In_Imm,16'h0}, Op=0000.
  - 110000 addi: A=In_Rs, B=SE, Op=0000.
  - 110010 andi: A=In_Rs, B=ZF, Op=0010.
  - 110011 ori: A=In_Rs, B=ZF, Op=0011.
  - Any other opcode, or an unlisted R-type func: illegal.
- Accept = In_Valid & In_Ready.
  - Illegal accept: not enqueued; Illegal=1 on the next cycle only.
- Buffering: main register M drives Out_*; skid register S; In_Ready = ~S.valid (registered, no combinational path from Out_Ready).
  - M empty, or M consumed (Out_Valid & Out_Ready) with S empty: a legal accept loads M. Latency 1 cycle, input edge to Out_Valid.
  - M consumed with S full: S moves to M. Any accept that cycle is impossible because In_Ready=0.
  - M held (Out_Valid & ~Out_Ready) and S empty: a legal accept loads S; In_Ready drops next cycle.
  - Order preserved strictly FIFO; no entry duplicated or lost.
- Out_A/B/Op/Rd are stable while Out_Valid=1 & Out_Ready=0.
- Out_* data holds its last value when Out_Valid=0; contents are don't-care to the consumer.
- Flush: both entries invalidated next edge; Flush has priority over a simultaneous accept (accepted entry discarded, Illegal not raised); In_Ready=1 afterwards.
- Reset mid-transfer: entries discarded immediately, no partial output.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs Issue_Cnt[15:0] and Illegal_Cnt[15:0].
  - Issue_Cnt increments on each Out_Valid & Out_Ready.
  - Illegal_Cnt increments on each illegal accept.
  - Both wrap at 16'hFFFF -> 0, reset to 0, are not cleared by Flush, and saturate-free.
- Undefined: counters and ports absent; all other behaviour identical.

Test Plan:
- addi: Rs=32'h0000_0005, Imm=16'hFFFF, Rd=3, Out_Ready=1 -> next cycle Out_Valid=1, A=5, B=32'hFFFF_FFFF, Op=0000, Rd=3.
- lui then ori back-to-back: Imm=16'h1234, then Rs=32'h1234_0000, Imm=16'h5678 -> entries in order: (A=0, B=32'h1234_0000, Op=0000), then (A=32'h1234_0000, B=32'h0000_5678, Op=0011).
- Backpressure: Out_Ready=0, issue 3 legal instructions -> first two accepted, In_Ready=0 on third. Raise Out_Ready -> all three delivered in order, none lost.
- Illegal: opcode 000111, then R-type func 110101 -> Illegal pulses 1 cycle each, Out_Valid stays 0. With ALU_ISSUE_STATS_EN: Illegal_Cnt=2.
- Flush with both entries full and a concurrent In_Valid -> next cycle Out_Valid=0, In_Ready=1, Illegal=0.
- Async reset asserted mid-stall -> Out_Valid=0 immediately, all outputs zero, normal operation resumes after release.
